// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and load/store.
// One transaction in flight; request ready is combinational in IDLE, responses are one-cycle pulses.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fetch_req_valid,
    input  logic [ADDR_WIDTH-1:0] fetch_req_addr,
    output logic                  fetch_req_ready,
    output logic                  fetch_resp_valid,
    output logic [DATA_WIDTH-1:0] fetch_resp_data,
    input  logic                  data_req_valid,
    input  logic [ADDR_WIDTH-1:0] data_req_addr,
    input  logic                  data_req_we,
    input  logic [DATA_WIDTH-1:0] data_req_wdata,
    output logic                  data_req_ready,
    output logic                  data_resp_valid,
    output logic [DATA_WIDTH-1:0] data_resp_data,
    output logic                  mem_valid,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ready,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  spurious_resp
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t                state_q;
    logic                  last_grant_q;   // 1 = data was granted last
    logic                  owner_q;        // 1 = data owns the transaction
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  we_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] fetch_rdata_q;
    logic [DATA_WIDTH-1:0] data_rdata_q;
    logic                  spurious_q;
    logic                  grant_fetch;
    logic                  grant_data;

    // On a tie, the requester that did not win last time gets the port.
    assign grant_fetch = !reset && (state_q == IDLE) && fetch_req_valid
                         && (!data_req_valid || last_grant_q);
    assign grant_data  = !reset && (state_q == IDLE) && data_req_valid
                         && (!fetch_req_valid || !last_grant_q);

    assign fetch_req_ready  = grant_fetch;
    assign data_req_ready   = grant_data;
    assign fetch_resp_valid = (state_q == RESP) && !owner_q;
    assign data_resp_valid  = (state_q == RESP) && owner_q;
    assign fetch_resp_data  = fetch_rdata_q;
    assign data_resp_data   = data_rdata_q;
    assign mem_valid        = (state_q == REQ);
    assign mem_addr         = addr_q;
    assign mem_we           = we_q;
    assign mem_wdata        = wdata_q;
    assign spurious_resp    = spurious_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            last_grant_q  <= 1'b1;
            owner_q       <= 1'b0;
            addr_q        <= '0;
            we_q          <= 1'b0;
            wdata_q       <= '0;
            fetch_rdata_q <= '0;
            data_rdata_q  <= '0;
            spurious_q    <= 1'b0;
        end else begin
            if (mem_rvalid && (state_q != WAIT)) begin
                spurious_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (grant_fetch) begin
                        owner_q      <= 1'b0;
                        last_grant_q <= 1'b0;
                        addr_q       <= {fetch_req_addr[ADDR_WIDTH-1:2], 2'b00};
                        we_q         <= 1'b0;
                        wdata_q      <= '0;
                        state_q      <= REQ;
                    end else if (grant_data) begin
                        owner_q      <= 1'b1;
                        last_grant_q <= 1'b1;
                        addr_q       <= data_req_addr;
                        we_q         <= data_req_we;
                        wdata_q      <= data_req_wdata;
                        state_q      <= REQ;
                    end
                end
                REQ: begin
                    if (mem_ready) begin
                        if (we_q) begin
                            data_rdata_q <= '0;
                            state_q      <= RESP;
                        end else begin
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        if (owner_q) begin
                            data_rdata_q <= mem_rdata;
                        end else begin
                            fetch_rdata_q <= mem_rdata;
                        end
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs change on the falling edge, outputs sampled 1ns later.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_req_valid;
    logic [31:0] fetch_req_addr;
    logic        fetch_req_ready;
    logic        fetch_resp_valid;
    logic [31:0] fetch_resp_data;
    logic        data_req_valid;
    logic [31:0] data_req_addr;
    logic        data_req_we;
    logic [31:0] data_req_wdata;
    logic        data_req_ready;
    logic        data_resp_valid;
    logic [31:0] data_resp_data;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        spurious_resp;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk              (clk),
        .reset            (reset),
        .fetch_req_valid  (fetch_req_valid),
        .fetch_req_addr   (fetch_req_addr),
        .fetch_req_ready  (fetch_req_ready),
        .fetch_resp_valid (fetch_resp_valid),
        .fetch_resp_data  (fetch_resp_data),
        .data_req_valid   (data_req_valid),
        .data_req_addr    (data_req_addr),
        .data_req_we      (data_req_we),
        .data_req_wdata   (data_req_wdata),
        .data_req_ready   (data_req_ready),
        .data_resp_valid  (data_resp_valid),
        .data_resp_data   (data_resp_data),
        .mem_valid        (mem_valid),
        .mem_addr         (mem_addr),
        .mem_we           (mem_we),
        .mem_wdata        (mem_wdata),
        .mem_ready        (mem_ready),
        .mem_rvalid       (mem_rvalid),
        .mem_rdata        (mem_rdata),
        .spurious_resp    (spurious_resp)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        reset = 1'b1;
        fetch_req_valid = 1'b0; fetch_req_addr = '0;
        data_req_valid = 1'b0; data_req_addr = '0; data_req_we = 1'b0; data_req_wdata = '0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

        // Reset values, and no ready while reset is asserted
        cyc(); cyc();
        fetch_req_valid = 1'b1; data_req_valid = 1'b1;
        settle();
        chk("rst_fetch_ready", fetch_req_ready, 0);
        chk("rst_data_ready", data_req_ready, 0);
        chk("rst_mem_valid", mem_valid, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_fresp_valid", fetch_resp_valid, 0);
        chk("rst_dresp_valid", data_resp_valid, 0);
        chk("rst_fresp_data", fetch_resp_data, 0);
        chk("rst_dresp_data", data_resp_data, 0);
        chk("rst_spurious", spurious_resp, 0);

        // Fetch only, unaligned address, immediate ready, rvalid next cycle
        cyc(); reset = 1'b0; data_req_valid = 1'b0;
        fetch_req_valid = 1'b1; fetch_req_addr = 32'h0000_1007; settle();
        chk("f1_accept", fetch_req_ready, 1);
        chk("f1_data_ready", data_req_ready, 0);
        cyc(); fetch_req_valid = 1'b0; fetch_req_addr = 32'hFFFF_FFFF; mem_ready = 1'b1; settle();
        chk("f1_mem_valid", mem_valid, 1);
        chk("f1_mem_addr", mem_addr, 32'h0000_1004);
        chk("f1_mem_we", mem_we, 0);
        chk("f1_mem_wdata", mem_wdata, 0);
        chk("f1_ready_busy", fetch_req_ready, 0);
        cyc(); mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF; settle();
        chk("f1_wait_mem_valid", mem_valid, 0);
        chk("f1_wait_resp", fetch_resp_valid, 0);
        cyc(); mem_rvalid = 1'b0; mem_rdata = '0; settle();
        chk("f1_resp_valid", fetch_resp_valid, 1);
        chk("f1_resp_data", fetch_resp_data, 32'hDEAD_BEEF);
        chk("f1_no_data_resp", data_resp_valid, 0);
        cyc(); settle();
        chk("f1_pulse_end", fetch_resp_valid, 0);
        chk("f1_data_hold", fetch_resp_data, 32'hDEAD_BEEF);
        chk("f1_spurious", spurious_resp, 0);

        // Load with 5-cycle rvalid delay while fetch waits; data wins the tie
        data_req_valid = 1'b1; data_req_addr = 32'h40; data_req_we = 1'b0; data_req_wdata = 32'h55;
        fetch_req_valid = 1'b1; fetch_req_addr = 32'h0000_2002; settle();
        chk("ld_data_ready", data_req_ready, 1);
        chk("ld_fetch_ready", fetch_req_ready, 0);
        cyc(); data_req_valid = 1'b0; mem_ready = 1'b1; settle();
        chk("ld_mem_addr", mem_addr, 32'h40);
        chk("ld_mem_we", mem_we, 0);
        chk("ld_fetch_ready_req", fetch_req_ready, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(); mem_ready = 1'b0; settle();
            chk("ld_wait_fetch_ready", fetch_req_ready, 0);
            chk("ld_wait_resp", data_resp_valid, 0);
        end
        cyc(); mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_0001; settle();
        chk("ld_rv_fetch_ready", fetch_req_ready, 0);
        cyc(); mem_rvalid = 1'b0; mem_rdata = '0; settle();
        chk("ld_resp_valid", data_resp_valid, 1);
        chk("ld_resp_data", data_resp_data, 32'hCAFE_0001);
        chk("ld_resp_fetch_ready", fetch_req_ready, 0);
        chk("ld_no_fetch_resp", fetch_resp_valid, 0);
        cyc(); settle();
        chk("f2_accept", fetch_req_ready, 1);
        chk("f2_pulse_end", data_resp_valid, 0);
        cyc(); fetch_req_valid = 1'b0; mem_ready = 1'b1; settle();
        chk("f2_mem_addr", mem_addr, 32'h0000_2000);
        cyc(); mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_F00D; settle();
        cyc(); mem_rvalid = 1'b0; settle();
        chk("f2_resp_valid", fetch_resp_valid, 1);
        chk("f2_resp_data", fetch_resp_data, 32'h0BAD_F00D);
        chk("f2_dresp_hold", data_resp_data, 32'hCAFE_0001);

        // Store with mem_ready held low 3 cycles
        cyc(); data_req_valid = 1'b1; data_req_addr = 32'h20; data_req_we = 1'b1;
        data_req_wdata = 32'h1234_5678; settle();
        chk("st_accept", data_req_ready, 1);
        for (int i = 0; i < 4; i++) begin
            cyc(); data_req_valid = 1'b0; data_req_addr = 32'hAAAA_AAAA; data_req_we = 1'b0;
            data_req_wdata = 32'h5555_5555; mem_ready = (i == 3); settle();
            chk("st_mem_valid", mem_valid, 1);
            chk("st_mem_addr", mem_addr, 32'h20);
            chk("st_mem_we", mem_we, 1);
            chk("st_mem_wdata", mem_wdata, 32'h1234_5678);
            chk("st_no_resp", data_resp_valid, 0);
        end
        cyc(); mem_ready = 1'b0; settle();
        chk("st_resp_valid", data_resp_valid, 1);
        chk("st_resp_data", data_resp_data, 0);
        chk("st_resp_mem_valid", mem_valid, 0);
        cyc(); settle();
        chk("st_pulse_end", data_resp_valid, 0);

        // Both requesters valid continuously from reset: fetch, data, fetch, data
        reset = 1'b1;
        cyc(); reset = 1'b0;
        fetch_req_valid = 1'b1; fetch_req_addr = 32'h0000_0103;
        data_req_valid = 1'b1; data_req_addr = 32'h0000_0203; data_req_we = 1'b1; data_req_wdata = 32'h0;
        for (int i = 0; i < 4; i++) begin
            logic exp_fetch;
            exp_fetch = (i % 2 == 0);
            data_req_wdata = 32'h1000 + i;
            settle();
            chk("rr_fetch_ready", fetch_req_ready, exp_fetch);
            chk("rr_data_ready", data_req_ready, !exp_fetch);
            cyc(); mem_ready = 1'b1; settle();
            chk("rr_mem_addr", mem_addr, exp_fetch ? 32'h0000_0100 : 32'h0000_0203);
            chk("rr_busy_ready", fetch_req_ready | data_req_ready, 0);
            if (exp_fetch) begin
                cyc(); mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h100 + i;
                settle();
                cyc(); mem_rvalid = 1'b0; settle();
                chk("rr_fresp", fetch_resp_valid, 1);
                chk("rr_fresp_data", fetch_resp_data, 32'h100 + i);
            end else begin
                cyc(); mem_ready = 1'b0; settle();
                chk("rr_dresp", data_resp_valid, 1);
                chk("rr_dresp_data", data_resp_data, 0);
            end
            chk("rr_resp_ready", fetch_req_ready | data_req_ready, 0);
            cyc();
        end
        fetch_req_valid = 1'b0; data_req_valid = 1'b0; data_req_we = 1'b0;

        // Reset during WAIT, then a late rvalid
        fetch_req_addr = 32'h300; fetch_req_valid = 1'b1; settle();
        chk("rw_accept", fetch_req_ready, 1);
        cyc(); fetch_req_valid = 1'b0; mem_ready = 1'b1; settle();
        cyc(); mem_ready = 1'b0; reset = 1'b1; settle();
        cyc(); reset = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h77; settle();
        chk("rw_mem_valid", mem_valid, 0);
        chk("rw_no_resp", fetch_resp_valid, 0);
        chk("rw_spur_pre", spurious_resp, 0);
        cyc(); mem_rvalid = 1'b0; settle();
        chk("rw_spur_set", spurious_resp, 1);
        chk("rw_no_resp2", fetch_resp_valid, 0);
        chk("rw_resp_data", fetch_resp_data, 0);
        fetch_req_valid = 1'b1; fetch_req_addr = 32'h404; settle();
        chk("rw_f_accept", fetch_req_ready, 1);
        cyc(); fetch_req_valid = 1'b0; mem_ready = 1'b1; settle();
        chk("rw_f_addr", mem_addr, 32'h404);
        cyc(); mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h99; settle();
        cyc(); mem_rvalid = 1'b0; settle();
        chk("rw_f_resp", fetch_resp_valid, 1);
        chk("rw_f_data", fetch_resp_data, 32'h99);
        chk("rw_spur_sticky", spurious_resp, 1);

        // rvalid in IDLE with no traffic
        cyc(); reset = 1'b1; settle();
        cyc(); reset = 1'b0; settle();
        chk("id_spur_clear", spurious_resp, 0);
        mem_rvalid = 1'b1; mem_rdata = 32'h1;
        cyc(); mem_rvalid = 1'b0; settle();
        chk("id_spur_set", spurious_resp, 1);
        chk("id_no_fresp", fetch_resp_valid, 0);
        chk("id_no_dresp", data_resp_valid, 0);
        chk("id_mem_valid", mem_valid, 0);
        cyc(); settle();
        chk("id_spur_hold", spurious_resp, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
